// File: rtl/multisim_client_push_buffered.sv
// Push-direction multisim client: buffers a valid/ready stream in a small FIFO and pushes
// entries in order to a named server, backing off for a programmable time after a rejection.

package multisim_client_pkg;
    localparam int MAX_W = 1024;
    // In-language stand-in for the client library: per-channel accept policy plus a call log.
    int unsigned start_calls = 0;
    string       last_dir = "";
    string       last_start_name = "";
    int          reject_next [string];
    int          accept_pct [string];
    string       log_name [$];
    logic [MAX_W-1:0] log_data [$];
    bit          log_acc [$];
    int          log_width [$];

    function automatic void multisim_client_start(input string dir, input string name);
        start_calls     = start_calls + 1;
        last_dir        = dir;
        last_start_name = name;
    endfunction

    function automatic int multisim_client_push_packed(input string name, input logic [MAX_W-1:0] data,
                                                       input int width);
        bit acc;
        if (reject_next.exists(name) && reject_next[name] > 0) begin
            reject_next[name] = reject_next[name] - 1;
            acc = 1'b0;
        end else if (accept_pct.exists(name)) begin
            acc = int'($urandom_range(32'd99, 32'd0)) < accept_pct[name];
        end else begin
            acc = 1'b1;
        end
        log_name.push_back(name);
        log_data.push_back(data);
        log_acc.push_back(acc);
        log_width.push_back(width);
        return {31'd0, acc};
    endfunction
endpackage

module multisim_client_push_buffered #(
    parameter int DATA_WIDTH     = 64,
    parameter bit DATA_IS_4STATE = 1'b0,
    parameter int DEPTH          = 4,
    parameter int BACKOFF_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  string                        server_runtime_directory,
    input  string                        server_name,
    input  logic                         data_vld,
    input  logic [DATA_WIDTH-1:0]        data,
    output logic                         data_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         server_busy
);
    import multisim_client_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    localparam logic [1:0] ST_WAIT_START = 2'd0;
    localparam logic [1:0] ST_RUN        = 2'd1;
    localparam logic [1:0] ST_BACKOFF    = 2'd2;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [CW-1:0] BO_LOAD    = (BACKOFF_CYCLES > 0) ? CW'(BACKOFF_CYCLES - 1) : '0;

    logic [1:0]      state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [CW-1:0]   bo_cnt_q;
    bit              started_q;

    logic            start_go_s;
    logic            started_d;
    logic            wr_en_s;
    logic            push_s;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_pop_d;
    logic [LW-1:0]   level_keep_d;
    logic [LW-1:0]   level_pop_d;
    logic [1:0]      state_idle_d;
    logic [1:0]      state_rej_d;
    logic [CW-1:0]   bo_idle_d;
    logic [DATA_WIDTH-1:0] head_s;
    logic [MAX_W-1:0]      head_wide_s;

    assign data_rdy    = (state_q != ST_WAIT_START) && (level_q < LEVEL_FULL);
    assign fifo_level  = level_q;
    assign server_busy = (state_q == ST_BACKOFF);
    assign head_wide_s = MAX_W'(head_s);

    // Next-state candidates; the push outcome selects between them at the clock edge.
    always_comb begin
`ifdef MULTISIM_EMULATION
        start_go_s = !started_q;
`else
        start_go_s = !started_q && (server_runtime_directory.len() != 0) && (server_name.len() != 0);
`endif
        started_d    = started_q | start_go_s;
        wr_en_s      = data_vld && data_rdy;
        push_s       = (state_q == ST_RUN) && (level_q != '0);
        wr_ptr_d     = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_pop_d = rd_ptr_q + AW'(1);
        level_keep_d = level_q + LW'(wr_en_s);
        level_pop_d  = level_keep_d - LW'(1);
        state_rej_d  = (BACKOFF_CYCLES > 0) ? ST_BACKOFF : ST_RUN;
        state_idle_d = state_q;
        bo_idle_d    = bo_cnt_q;
        case (state_q)
            ST_WAIT_START: begin
                state_idle_d = started_d ? ST_RUN : ST_WAIT_START;
            end
            ST_RUN: begin
                state_idle_d = ST_RUN;
            end
            ST_BACKOFF: begin
                if (bo_cnt_q == '0) begin
                    state_idle_d = ST_RUN;
                end else begin
                    state_idle_d = ST_BACKOFF;
                    bo_idle_d    = bo_cnt_q - CW'(1);
                end
            end
            default: begin
                state_idle_d = ST_WAIT_START;
            end
        endcase
    end

    // One-time server start; deliberately independent of rst_n.
    always_ff @(posedge clk) begin
        if (start_go_s) begin
            multisim_client_start(server_runtime_directory, server_name);
            started_q <= 1'b1;
        end
    end

    // Control state, pointers and level; the push call itself happens here so it fires once per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= started_d ? ST_RUN : ST_WAIT_START;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            bo_cnt_q <= '0;
        end else if (push_s) begin
            wr_ptr_q <= wr_ptr_d;
            if ((multisim_client_push_packed(server_name, head_wide_s, DATA_WIDTH) & 32'sd1) != 32'sd0) begin
                rd_ptr_q <= rd_ptr_pop_d;
                level_q  <= level_pop_d;
                state_q  <= ST_RUN;
            end else begin
                level_q  <= level_keep_d;
                state_q  <= state_rej_d;
                bo_cnt_q <= BO_LOAD;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_keep_d;
            state_q  <= state_idle_d;
            bo_cnt_q <= bo_idle_d;
        end
    end

    if (DATA_IS_4STATE) begin : g_mem4
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        // Payload storage, 4-state.
        always_ff @(posedge clk) begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= data;
            end
        end
        assign head_s = mem_q[rd_ptr_q];
    end else begin : g_mem2
        bit [DATA_WIDTH-1:0] mem_q [DEPTH];
        // Payload storage, 2-state (X/Z land as 0).
        always_ff @(posedge clk) begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= data;
            end
        end
        assign head_s = mem_q[rd_ptr_q];
    end

endmodule

// File: doc/multisim_client_push_buffered.md
# multisim_client_push_buffered

Client-side transmitter of the multisim channel protocol. It accepts a valid/ready stream from the local design, buffers it in a small FIFO, and pushes entries in order to the named server over the multisim DPI client API. When the server reports busy, it retries after a programmable backoff. It is the push-direction counterpart of the pull client and sits at the boundary of a partitioned simulation.

## Interface
- DATA_WIDTH, 64, payload width in bits.
- DATA_IS_4STATE, 0, when 1, FIFO storage is 4-state `logic`; when 0, storage is `bit` and X/Z are captured as 0.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- BACKOFF_CYCLES, 0, idle cycles after a rejected push before retrying; 0 means retry on the next edge.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- server_runtime_directory  input  string  server runtime directory.
- server_name  input  string  server/channel name passed to every DPI call.
- data_vld  input  1  upstream data valid.
- data  input  DATA_WIDTH  upstream payload.
- data_rdy  output  1  block can accept `data` this cycle.
- fifo_level  output  $clog2(DEPTH+1)  entries currently buffered.
- server_busy  output  1  high while in BACKOFF.

## Operation
- Startup:
  - In non-emulation builds, an initial process waits until both strings are non-empty.
  - It then calls `multisim_client_start(server_runtime_directory, server_name)` and sets the internal `started` flag.
  - Under `MULTISIM_EMULATION`, the call is made immediately.
  - `started` is not affected by rst_n, and start is never re-issued.
- States:
  - WAIT_START: not started.
  - RUN.
  - BACKOFF: counting down after a rejection.
- Transitions:
  - WAIT_START→RUN on the first posedge with `started`=1.
  - RUN→BACKOFF when a push is rejected and BACKOFF_CYCLES>0.
  - BACKOFF→RUN when the counter reaches 0.
- Accept side:
  - data_rdy = (state≠WAIT_START) && (fifo_level<DEPTH). It is combinational from registers only and never depends on data_vld.
  - A transfer occurs on a posedge with data_vld && data_rdy. The payload is written at the tail.
- Drain side:
  - In RUN with fifo_level>0, each posedge calls `multisim_client_push_packed(server_name, head, DATA_WIDTH)`. The head is the entry present before that edge's write.
  - Bit 0 of the return value is the acceptance flag: 1 pops the head; 0 leaves the head in place.
  - No DPI call is made in WAIT_START or BACKOFF, or when the FIFO is empty.
- Rejection:
  - The backoff counter loads BACKOFF_CYCLES−1 and the state enters BACKOFF.
  - The counter decrements each cycle. At 0, the state returns to RUN, and the next edge retries the same head.
- Ordering: entries reach the server strictly in acceptance order, with no duplication or loss while rst_n is high.
- Pointers wrap modulo DEPTH. fifo_level updates with the net effect of write and pop on the same edge (+1, −1, or 0).
- Reset (rst_n=0 at a posedge):
  - Pointers, fifo_level and the backoff counter clear.
  - State becomes RUN if `started`, else WAIT_START.
  - Buffered entries are discarded and are not pushed.
  - A DPI call is not made on a reset edge.

## Timing
- Reset values: data_rdy=0 if not started, else 1; fifo_level=0; server_busy=0.
- Latency: data accepted at edge N into an empty FIFO is pushed by the DPI call at edge N+1 at the earliest.
- Throughput: 1 entry/cycle sustained when the server always accepts.
- Full: data_rdy=0 at fifo_level=DEPTH, even if the head is popped on the same edge. The freed slot is visible as data_rdy=1 one cycle later.
- Empty with a simultaneous write: no pop on that edge, and fifo_level becomes 1.
- Rejection with BACKOFF_CYCLES=B>0:
  - server_busy is high for exactly B cycles.
  - The retry DPI call occurs B+1 edges after the rejected call.
- Rejection with BACKOFF_CYCLES=0: the state stays in RUN, server_busy stays 0, and the call is retried on the next edge.
- Upstream writes continue during BACKOFF while not full.

## Test plan
- Startup gating: hold server_name="" for 10 cycles with data_vld=1 → data_rdy=0, no DPI calls. Set the name → data_rdy=1 the cycle after start, first push one edge after the first accept.
- Streaming: DEPTH=4, server always accepts, send 0x1..0x20 back-to-back → server receives 0x1..0x20 in order, data_rdy stays 1, fifo_level≤1.
- Backpressure to full: server rejects for 12 calls with BACKOFF_CYCLES=2, send 6 words → fifo_level reaches 4, data_rdy=0, server_busy pulses 2 cycles per rejection, all 6 words are delivered in order afterwards.
- Zero backoff: BACKOFF_CYCLES=0, server rejects 3 times → head retried on 3 consecutive edges, server_busy never asserted.
- Wrap-around: 3×DEPTH words with alternating accept/reject → no loss or duplication, fifo_level consistent each cycle.
- Reset mid-operation: assert rst_n=0 with 3 entries buffered and in BACKOFF → fifo_level=0, server_busy=0, data_rdy=1 next cycle, discarded entries never pushed, no restart call issued.
